iobus_sequencer: RTL and testbench
==================================

// Module: iobus_sequencer
// PURPOSE
//  Master-side IO bus transaction sequencer. Accepts one command at a time
//  (DATAO, CONO, DATAI, CONI, IORST) over a valid/ready handshake and emits the
//  timed control pulses, device select and write data on the IO bus master
//  port. Read data is captured from the bus. Its outputs drive the master
//  inputs of the IO bus fan-out; its iob_read input comes from that fan-out.
// PARAMETERS
//  PULSE_LEN  2  cycles each clear/set/iob_reset pulse is held (>=1)
//  GAP        1  idle cycles after the clear pulse and after the set pulse (>=1)
//  SETTLE     4  cycles fm_datai/fm_status held before read capture (>=1)
// PORTS
//  clk             in   1   system clock
//  reset           in   1   synchronous, active-high reset
//  cmd_valid       in   1   command offered
//  cmd_ready       out  1   sequencer idle, command will be accepted
//  cmd_op          in   3   0 DATAO, 1 CONO, 2 DATAI, 3 CONI, 4 IORST, 5-7 illegal
//  cmd_dev         in   7   device code, driven on ios[3:9]
//  cmd_wdata       in   36  write word for DATAO/CONO
//  done            out  1   one-cycle completion pulse
//  err             out  1   valid with done; 1 = illegal op
//  rdata           out  36  captured read word; holds until next read completes
//  iob_poweron     out  1   bus power-on level
//  iob_reset       out  1   bus reset pulse
//  datao_clear, datao_set, cono_clear, cono_set  out 1 each  bus control pulses
//  iob_fm_datai, iob_fm_status  out 1 each  bus read strobes
//  ios             out  7   device select [3:9]
//  iob_write       out  36  bus write data [0:35]
//  iob_read        in   36  bus read data [0:35]
// BEHAVIOUR
//  - Reset values: cmd_ready=0 during reset, 1 from the first cycle after;
//    iob_poweron=0 during reset, 1 from the first cycle after. All pulses, done,
//    err, ios, iob_write=0. rdata=0.
//  - Reset mid-transaction: abandon at the next edge; no done; outputs as above.
//  - States: IDLE, CLR, GAP1, SET, GAP2, RD, RST, FIN.
//  - Accept = cmd_valid & cmd_ready. cmd_ready=1 only in IDLE. op/dev/wdata are
//    latched on accept; later input changes are ignored.
//  - DATAO/CONO: CLR (PULSE_LEN cyc, *_clear=1) -> GAP1 (GAP cyc) ->
//    SET (PULSE_LEN cyc, *_set=1) -> GAP2 (GAP cyc) -> FIN.
//    DATAO uses the datao_* pair and CONO uses the cono_* pair.
//  - DATAI/CONI: RD (SETTLE cyc, iob_fm_datai or iob_fm_status=1) -> FIN.
//    rdata <= iob_read at the edge ending the last RD cycle.
//  - IORST: RST (PULSE_LEN cyc, iob_reset=1) -> FIN. ios=0 throughout.
//  - Illegal op: IDLE -> FIN directly, err=1, no bus activity.
//  - FIN: done=1 for one cycle, err valid, then IDLE. The next accept is
//    possible in the cycle after FIN.
//  - ios=latched dev in every non-IDLE, non-FIN state of DATAO/CONO/DATAI/CONI
//    and 0 otherwise.
//  - iob_write=latched wdata from CLR through GAP2 of DATAO/CONO, otherwise 0.
//    It must be 0 during reads because the bus ORs write data into read data.
//  - Latency, accept at cycle 0: write done at cycle 1+2*PULSE_LEN+2*GAP;
//    read done at SETTLE+1; IORST done at PULSE_LEN+1; illegal done at 1.
//  - Use state counters sized for max(PULSE_LEN,GAP,SETTLE). Never more than
//    one control pulse is high at once.
// TESTING
//  - Reset 3 cyc, then release -> cycle after release: iob_poweron=1,
//    cmd_ready=1, all other outputs 0.
//  - DATAO dev=7'o011, wdata=36'o123456701234, defaults -> datao_clear cyc 1-2,
//    datao_set cyc 4-5, ios=7'o011 and iob_write valid cyc 1-6, done cyc 7, err=0.
//  - CONI dev=7'o004, iob_read=36'o777000000001 -> iob_fm_status cyc 1-4,
//    iob_write=0 throughout, done cyc 5, rdata=36'o777000000001.
//  - cmd_op=6 -> done and err at cyc 1; no pulse, ios=0, iob_write=0.
//  - reset asserted during SET of a CONO -> cono_set, ios and iob_write drop
//    after the edge; no done; cmd_ready=1 the cycle after release.
//  - Back-to-back: cmd_valid held with IORST then DATAI -> iob_reset cyc 1-2,
//    done cyc 3, second accept cyc 4, iob_fm_datai cyc 5-8, done cyc 9.

Source files
------------

// File: rtl/iobus_sequencer_if.sv
// IO bus sequencer interface: command handshake, completion/read-back and
// the IO bus master-side signals.
//   master modport: command source / bus fan-out side (drives cmd_*, iob_read)
//   slave  modport: the sequencer (drives cmd_ready, done, err, rdata, bus ctl)
interface iobus_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [6:0]  cmd_dev;
  logic [0:35] cmd_wdata;
  logic        done;
  logic        err;
  logic [0:35] rdata;
  logic        iob_poweron;
  logic        iob_reset;
  logic        datao_clear;
  logic        datao_set;
  logic        cono_clear;
  logic        cono_set;
  logic        iob_fm_datai;
  logic        iob_fm_status;
  logic [3:9]  ios;
  logic [0:35] iob_write;
  logic [0:35] iob_read;

  modport master (
    output cmd_valid, cmd_op, cmd_dev, cmd_wdata, iob_read,
    input  cmd_ready, done, err, rdata, iob_poweron, iob_reset,
           datao_clear, datao_set, cono_clear, cono_set,
           iob_fm_datai, iob_fm_status, ios, iob_write
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_dev, cmd_wdata, iob_read,
    output cmd_ready, done, err, rdata, iob_poweron, iob_reset,
           datao_clear, datao_set, cono_clear, cono_set,
           iob_fm_datai, iob_fm_status, ios, iob_write
  );
endinterface

// File: rtl/iobus_sequencer.sv
// Master-side IO bus transaction sequencer. Accepts one command at a time
// (DATAO, CONO, DATAI, CONI, IORST) and emits timed clear/set/reset pulses,
// read strobes, device select and write data; captures read data.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave modport of iobus_sequencer_if (handshake + IO bus)
module iobus_sequencer #(
  parameter int PULSE_LEN = 2,
  parameter int GAP       = 1,
  parameter int SETTLE    = 4
) (
  input  logic clk,
  input  logic reset,
  iobus_sequencer_if.slave bus
);

  localparam int MAXA = (PULSE_LEN > GAP) ? PULSE_LEN : GAP;
  localparam int MAXC = (MAXA > SETTLE) ? MAXA : SETTLE;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [2:0] {
    IDLE, CLR, GAP1, SET, GAP2, RD, RST, FIN
  } state_t;

  typedef enum logic [2:0] {
    OP_DATAO = 3'd0,
    OP_CONO  = 3'd1,
    OP_DATAI = 3'd2,
    OP_CONI  = 3'd3,
    OP_IORST = 3'd4
  } op_t;

  state_t      state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]  op_q, op_cur;
  logic [6:0]  dev_q, dev_cur;
  logic [0:35] wdata_q, wdata_cur;
  logic        accept;
  logic        wr_phase;
  logic        sel_phase;

  // In IDLE the command inputs are used directly so the first bus state's
  // outputs can be registered at the accept edge itself.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    op_cur    = (state == IDLE) ? bus.cmd_op    : op_q;
    dev_cur   = (state == IDLE) ? bus.cmd_dev   : dev_q;
    wdata_cur = (state == IDLE) ? bus.cmd_wdata : wdata_q;
    accept    = bus.cmd_valid & bus.cmd_ready;
    unique case (state)
      IDLE: if (accept) begin
        if (op_cur == OP_DATAO || op_cur == OP_CONO) begin
          state_nxt = CLR;
          cnt_nxt   = CW'(PULSE_LEN - 1);
        end else if (op_cur == OP_DATAI || op_cur == OP_CONI) begin
          state_nxt = RD;
          cnt_nxt   = CW'(SETTLE - 1);
        end else if (op_cur == OP_IORST) begin
          state_nxt = RST;
          cnt_nxt   = CW'(PULSE_LEN - 1);
        end else begin
          state_nxt = FIN;
        end
      end
      CLR: if (cnt == '0) begin
        state_nxt = GAP1;
        cnt_nxt   = CW'(GAP - 1);
      end else cnt_nxt = cnt - 1'b1;
      GAP1: if (cnt == '0) begin
        state_nxt = SET;
        cnt_nxt   = CW'(PULSE_LEN - 1);
      end else cnt_nxt = cnt - 1'b1;
      SET: if (cnt == '0) begin
        state_nxt = GAP2;
        cnt_nxt   = CW'(GAP - 1);
      end else cnt_nxt = cnt - 1'b1;
      GAP2, RD, RST: if (cnt == '0) state_nxt = FIN;
                     else cnt_nxt = cnt - 1'b1;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    wr_phase  = (state_nxt == CLR) || (state_nxt == GAP1) ||
                (state_nxt == SET) || (state_nxt == GAP2);
    sel_phase = wr_phase || (state_nxt == RD);
  end

  // Outputs are decoded from the next state so they are registered and
  // line up exactly with the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      op_q          <= '0;
      dev_q         <= '0;
      wdata_q       <= '0;
      bus.cmd_ready     <= 1'b0;
      bus.iob_poweron   <= 1'b0;
      bus.done          <= 1'b0;
      bus.err           <= 1'b0;
      bus.rdata         <= '0;
      bus.iob_reset     <= 1'b0;
      bus.datao_clear   <= 1'b0;
      bus.datao_set     <= 1'b0;
      bus.cono_clear    <= 1'b0;
      bus.cono_set      <= 1'b0;
      bus.iob_fm_datai  <= 1'b0;
      bus.iob_fm_status <= 1'b0;
      bus.ios           <= '0;
      bus.iob_write     <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        op_q    <= bus.cmd_op;
        dev_q   <= bus.cmd_dev;
        wdata_q <= bus.cmd_wdata;
      end
      if (state == RD && cnt == '0)
        bus.rdata <= bus.iob_read;
      bus.cmd_ready     <= (state_nxt == IDLE);
      bus.iob_poweron   <= 1'b1;
      bus.done          <= (state_nxt == FIN);
      bus.err           <= (state_nxt == FIN) && (op_cur > 3'd4);
      bus.iob_reset     <= (state_nxt == RST);
      bus.datao_clear   <= (state_nxt == CLR) && (op_cur == OP_DATAO);
      bus.datao_set     <= (state_nxt == SET) && (op_cur == OP_DATAO);
      bus.cono_clear    <= (state_nxt == CLR) && (op_cur == OP_CONO);
      bus.cono_set      <= (state_nxt == SET) && (op_cur == OP_CONO);
      bus.iob_fm_datai  <= (state_nxt == RD) && (op_cur == OP_DATAI);
      bus.iob_fm_status <= (state_nxt == RD) && (op_cur == OP_CONI);
      bus.ios           <= sel_phase ? dev_cur : '0;
      bus.iob_write     <= wr_phase ? wdata_cur : '0;
    end
  end

endmodule

// File: tb/tb_iobus_sequencer.sv
module tb_iobus_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  iobus_sequencer_if bus();

  iobus_sequencer #(.PULSE_LEN(2), .GAP(1), .SETTLE(4)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Windows are cycle ranges relative to the accept cycle (cycle 0);
  // lo > hi means the window is empty.
  typedef struct {
    logic [2:0]  op;
    logic [6:0]  dev;
    logic [35:0] wdata;
    logic [35:0] rd;
    int          a_lo, a_hi, b_lo, b_hi;
    int          io_hi, wr_hi, done_cyc;
    logic        err;
    logic [35:0] rdata;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %o expected %o", name, act, exp);
    end
  endtask

  // bit order: iob_reset, datao_clear, datao_set, cono_clear, cono_set, fm_datai, fm_status
  function automatic logic [6:0] pulses();
    return {bus.iob_reset, bus.datao_clear, bus.datao_set, bus.cono_clear,
            bus.cono_set, bus.iob_fm_datai, bus.iob_fm_status};
  endfunction

  function automatic logic [6:0] exp_pulses(input vec_t v, input int c);
    logic a, b;
    a = (c >= v.a_lo) && (c <= v.a_hi);
    b = (c >= v.b_lo) && (c <= v.b_hi);
    case (v.op)
      3'd0:    return {1'b0, a, b, 4'b0};
      3'd1:    return {3'b0, a, b, 2'b0};
      3'd2:    return {5'b0, a, 1'b0};
      3'd3:    return {6'b0, a};
      3'd4:    return {a, 6'b0};
      default: return 7'b0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = v.op;
    bus.cmd_dev   = v.dev;
    bus.cmd_wdata = v.wdata;
    bus.iob_read  = v.rd;
    tick();
    // scramble command inputs: the latched copy must be used
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd5;
    bus.cmd_dev   = ~v.dev;
    bus.cmd_wdata = ~v.wdata;
    for (int c = 1; c <= v.done_cyc + 1; c++) begin
      tag = $sformatf("v%0d c%0d", idx, c);
      chk({tag, " pulses"}, 36'(pulses()), 36'(exp_pulses(v, c)));
      chk({tag, " ios"}, 36'(bus.ios), (c <= v.io_hi) ? 36'(v.dev) : 36'd0);
      chk({tag, " iob_write"}, bus.iob_write, (c <= v.wr_hi) ? v.wdata : 36'd0);
      chk({tag, " done/err/ready"}, 36'({bus.done, bus.err, bus.cmd_ready}),
          36'({c == v.done_cyc, (c == v.done_cyc) && v.err, c == v.done_cyc + 1}));
      if (c == v.done_cyc)
        chk({tag, " rdata"}, bus.rdata, v.rdata);
      if (c <= v.done_cyc) tick();
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_dev   = '0;
    bus.cmd_wdata = '0;
    bus.iob_read  = '0;

    //        op    dev     wdata               iob_read            a_lo a_hi b_lo b_hi io wr done err rdata
    vecs[0] = '{3'd0, 7'o011, 36'o123456701234, 36'o555555555555, 1, 2, 4, 5, 6, 6, 7, 1'b0, 36'o0};
    vecs[1] = '{3'd3, 7'o004, 36'o707070707070, 36'o777000000001, 1, 4, 9, 0, 4, 0, 5, 1'b0, 36'o777000000001};
    vecs[2] = '{3'd6, 7'o055, 36'o111111111111, 36'o222222222222, 9, 0, 9, 0, 0, 0, 1, 1'b1, 36'o777000000001};
    vecs[3] = '{3'd1, 7'o177, 36'o777777777777, 36'o0,            1, 2, 4, 5, 6, 6, 7, 1'b0, 36'o777000000001};
    vecs[4] = '{3'd2, 7'o100, 36'o123123123123, 36'o000000000777, 1, 4, 9, 0, 4, 0, 5, 1'b0, 36'o000000000777};
    vecs[5] = '{3'd4, 7'o055, 36'o444444444444, 36'o333333333333, 1, 2, 9, 0, 0, 0, 3, 1'b0, 36'o000000000777};
    vecs[6] = '{3'd7, 7'o001, 36'o0,            36'o0,            9, 0, 9, 0, 0, 0, 1, 1'b1, 36'o000000000777};
    vecs[7] = '{3'd5, 7'o177, 36'o1,            36'o0,            9, 0, 9, 0, 0, 0, 1, 1'b1, 36'o000000000777};

    // reset for 3 cycles
    repeat (3) tick();
    chk("in reset ready/poweron", 36'({bus.cmd_ready, bus.iob_poweron}), 36'd0);
    reset = 1'b0;
    tick();
    chk("post reset ready/poweron", 36'({bus.cmd_ready, bus.iob_poweron}), 36'b11);
    chk("post reset pulses", 36'(pulses()), 36'd0);
    chk("post reset done/err", 36'({bus.done, bus.err}), 36'd0);
    chk("post reset ios", 36'(bus.ios), 36'd0);
    chk("post reset iob_write", bus.iob_write, 36'd0);
    chk("post reset rdata", bus.rdata, 36'd0);

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // reset during SET of a CONO
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'd1;
    bus.cmd_dev   = 7'o033;
    bus.cmd_wdata = 36'o525252525252;
    tick();
    bus.cmd_valid = 1'b0;
    repeat (3) tick();
    chk("midrst in SET cono_set", 36'(pulses()), 36'(7'b0000100));
    reset = 1'b1;
    tick();
    chk("midrst pulses", 36'(pulses()), 36'd0);
    chk("midrst ios", 36'(bus.ios), 36'd0);
    chk("midrst iob_write", bus.iob_write, 36'd0);
    chk("midrst done/ready/poweron", 36'({bus.done, bus.cmd_ready, bus.iob_poweron}), 36'd0);
    chk("midrst rdata", bus.rdata, 36'd0);
    reset = 1'b0;
    tick();
    chk("after midrst ready", 36'(bus.cmd_ready), 36'd1);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("after midrst c%0d done/pulses", c), 36'({bus.done, pulses()}), 36'd0);
      tick();
    end

    // back-to-back: IORST then DATAI with cmd_valid held
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'd4;
    bus.cmd_dev   = 7'o066;
    bus.cmd_wdata = 36'o0;
    bus.iob_read  = 36'o246024602460;
    tick();
    bus.cmd_op    = 3'd2;
    bus.cmd_dev   = 7'o014;
    for (int c = 1; c <= 9; c++) begin
      chk($sformatf("b2b c%0d pulses", c), 36'(pulses()),
          36'({(c <= 2), 4'b0, (c >= 5 && c <= 8), 1'b0}));
      chk($sformatf("b2b c%0d done/ready", c), 36'({bus.done, bus.cmd_ready}),
          36'({(c == 3 || c == 9), (c == 4)}));
      chk($sformatf("b2b c%0d ios", c), 36'(bus.ios),
          (c >= 5 && c <= 8) ? 36'(7'o014) : 36'd0);
      if (c == 9) chk("b2b rdata", bus.rdata, 36'o246024602460);
      if (c == 5) bus.cmd_valid = 1'b0;
      if (c < 9) tick();
    end
    tick();
    chk("b2b idle ready", 36'(bus.cmd_ready), 36'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
